fetch_buffer: RTL

- Instruction prefetch unit directly upstream of the IF stage and the IF/ID register. It replaces the direct PC-to-imem path.
- Issues sequential word fetches to instruction memory over a valid/ready request channel. Buffers in-order responses, tagged with their PC, in a small FIFO and presents them to IF/ID.
- On an EX-stage redirect (PCSrcE/PCTargetE) it flushes the FIFO and squashes in-flight stale responses.
- Honours StallF from the hazard unit.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/fetch_buffer.sv | 84 ++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: fetch entry type and NOP encoding shared by the prefetch unit
// The fault field exists only when FETCH_BUF_ERR_EN is defined.
package pipeline_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0] instr;
`ifdef FETCH_BUF_ERR_EN
    logic fault;
`endif
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush and a registered head
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] cnt_nxt;
  assign rd_nxt = rd_ptr + AW'(pop);
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  // head only moves while something remains, so pc holds its last value when empty
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_nxt;
      count <= cnt_nxt;
      if (cnt_nxt != '0) head <= (push && wr_ptr == rd_nxt) ? push_data : mem[rd_nxt];
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: credit-limited instruction prefetcher with redirect flush and stale-response squash
// Optional FETCH_BUF_ERR_EN adds response error tagging and fetch halt until redirect.
module fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int XLEN = PC_W,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_BUF_ERR_EN
  ,
  input  logic            imem_rsp_err_i,
  output logic            instr_fault_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic accept, push, pop, halted;
  fetch_entry_t push_data, head;
`ifdef FETCH_BUF_ERR_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) halted <= 1'b0;
    else if (redirect_i) halted <= 1'b0;
    else if (push && imem_rsp_err_i) halted <= 1'b1;
  assign push_data = '{pc: rsp_pc, instr: imem_rsp_data_i, fault: imem_rsp_err_i};
  assign instr_fault_o = instr_valid_o && head.fault;
`else
  assign halted = 1'b0;
  assign push_data = '{pc: rsp_pc, instr: imem_rsp_data_i};
`endif
  // buffered plus in-flight never exceeds DEPTH, so every response has a slot
  assign imem_req_valid_o = reset && !redirect_i && !halted &&
                            ({1'b0, count} + {1'b0, outstanding} < (CW + 1)'(DEPTH));
  assign imem_req_addr_o = {fetch_pc[XLEN-1:2], 2'b00};
  assign accept = imem_req_valid_o && imem_req_ready_i;
  assign push = imem_rsp_valid_i && discard == '0 && !redirect_i;
  assign pop = instr_valid_o && !stall_i && !redirect_i;
  assign instr_valid_o = count != '0;
  assign instr_o = instr_valid_o ? head.instr : NOP_INSTR;
  assign pc_o = head.pc;
  assign pc_plus4_o = pc_o + XLEN'(4);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      rsp_pc <= redirect_pc_i;
      outstanding <= outstanding - CW'(imem_rsp_valid_i);
      discard <= outstanding - CW'(imem_rsp_valid_i);
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) rsp_pc <= rsp_pc + XLEN'(4);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i && discard != '0) discard <= discard - CW'(1);
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .flush(redirect_i),
    .count(count),
    .head(head)
  );
endmodule
